// File: rtl/rb_pkg.sv
// Shared definitions for the forwarding register bank: default widths and
// the operand source codes reported on fwd_A / fwd_B.
package rb_pkg;

  localparam int RB_DATA_W = 16;
  localparam int RB_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_FILE = 2'b00,
    FWD_EX   = 2'b01,
    FWD_DM   = 2'b10,
    FWD_WB   = 2'b11   // also reported when B takes the immediate
  } fwd_src_e;

endpackage

// File: rtl/rb_fwd_block_if.sv
// Decode-side bus of the forwarding register bank: operand requests, the
// EX/DM/WB result buses, and the registered operands handed to execute.
interface rb_fwd_block_if
  import rb_pkg::*;
#(
  parameter int DATA_W = RB_DATA_W,
  parameter int ADDR_W = RB_ADDR_W
) ();

  logic [ADDR_W-1:0] RA;
  logic [ADDR_W-1:0] RB;
  logic [DATA_W-1:0] imm;
  logic              imm_sel;
  logic [DATA_W-1:0] ans_ex;
  logic [ADDR_W-1:0] RW_ex;
  logic              wr_ex;
  logic              ld_ex;
  logic [DATA_W-1:0] ans_dm;
  logic [ADDR_W-1:0] RW_dm;
  logic              wr_dm;
  logic [DATA_W-1:0] ans_wb;
  logic [ADDR_W-1:0] RW_wb;
  logic              wr_wb;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              stall;
  logic [1:0]        fwd_A;
  logic [1:0]        fwd_B;

  modport master (
    output RA, RB, imm, imm_sel,
    output ans_ex, RW_ex, wr_ex, ld_ex,
    output ans_dm, RW_dm, wr_dm,
    output ans_wb, RW_wb, wr_wb,
    input  A, B, stall, fwd_A, fwd_B
  );

  modport slave (
    input  RA, RB, imm, imm_sel,
    input  ans_ex, RW_ex, wr_ex, ld_ex,
    input  ans_dm, RW_dm, wr_dm,
    input  ans_wb, RW_wb, wr_wb,
    output A, B, stall, fwd_A, fwd_B
  );

endinterface

// File: rtl/rb_fwd_sel.sv
// Combinational operand selector: picks the youngest in-flight result for one
// source register and flags a load-use hazard on that source.
module rb_fwd_sel
  import rb_pkg::*;
#(
  parameter int DATA_W   = RB_DATA_W,
  parameter int ADDR_W   = RB_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [ADDR_W-1:0] src,
  input  logic              use_imm,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] file_data,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [ADDR_W-1:0] rw_ex,
  input  logic              wr_ex,
  input  logic              ld_ex,
  input  logic [DATA_W-1:0] ans_dm,
  input  logic [ADDR_W-1:0] rw_dm,
  input  logic              wr_dm,
  input  logic [DATA_W-1:0] ans_wb,
  input  logic [ADDR_W-1:0] rw_wb,
  input  logic              wr_wb,
  output logic [DATA_W-1:0] data,
  output fwd_src_e          code,
  output logic              load_hazard
);

  logic is_zero;

  assign is_zero = ZERO_REG && (src == '0);

  // NOTE: every output gets a default before the if-chain so no path can infer a latch.
  always_comb begin
    data = file_data;
    code = FWD_FILE;
    if (use_imm) begin
      data = imm;
      code = FWD_WB;
    end else if (is_zero) begin
      data = '0;
      code = FWD_FILE;
    end else if (wr_ex && !ld_ex && (rw_ex == src)) begin
      data = ans_ex;
      code = FWD_EX;
    end else if (wr_dm && (rw_dm == src)) begin
      data = ans_dm;
      code = FWD_DM;
    end else if (wr_wb && (rw_wb == src)) begin
      data = ans_wb;
      code = FWD_WB;
    end
  end

  // A load in EX cannot supply its value yet, so a matching source must wait.
  assign load_hazard = !use_imm && !is_zero && wr_ex && ld_ex && (rw_ex == src);

endmodule

// File: rtl/rb_fwd_block.sv
// Register bank with internal operand forwarding and load-use stall,
// registering the A/B operands for the EX stage.
module rb_fwd_block
  import rb_pkg::*;
#(
  parameter int DATA_W   = RB_DATA_W,
  parameter int ADDR_W   = RB_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  rb_fwd_block_if.slave bus
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, a_sel, b_sel;
  fwd_src_e          fa_q, fa_d, fb_q, fb_d, fa_sel, fb_sel;
  logic              hz_a, hz_b, stall;

  rb_fwd_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sel_a (
    .src(bus.RA), .use_imm(1'b0), .imm('0), .file_data(rf_q[bus.RA]),
    .ans_ex(bus.ans_ex), .rw_ex(bus.RW_ex), .wr_ex(bus.wr_ex), .ld_ex(bus.ld_ex),
    .ans_dm(bus.ans_dm), .rw_dm(bus.RW_dm), .wr_dm(bus.wr_dm),
    .ans_wb(bus.ans_wb), .rw_wb(bus.RW_wb), .wr_wb(bus.wr_wb),
    .data(a_sel), .code(fa_sel), .load_hazard(hz_a)
  );

  rb_fwd_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sel_b (
    .src(bus.RB), .use_imm(bus.imm_sel), .imm(bus.imm), .file_data(rf_q[bus.RB]),
    .ans_ex(bus.ans_ex), .rw_ex(bus.RW_ex), .wr_ex(bus.wr_ex), .ld_ex(bus.ld_ex),
    .ans_dm(bus.ans_dm), .rw_dm(bus.RW_dm), .wr_dm(bus.wr_dm),
    .ans_wb(bus.ans_wb), .rw_wb(bus.RW_wb), .wr_wb(bus.wr_wb),
    .data(b_sel), .code(fb_sel), .load_hazard(hz_b)
  );

  assign stall = hz_a | hz_b;

  // Write-back proceeds even while stalled; register 0 stays hard-wired when enabled.
  always_comb begin
    rf_d = rf_q;
    if (bus.wr_wb && !(ZERO_REG && (bus.RW_wb == '0))) begin
      rf_d[bus.RW_wb] = bus.ans_wb;
    end
  end

  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    fa_d = fa_q;
    fb_d = fb_q;
    if (!stall) begin
      a_d  = a_sel;
      b_d  = b_sel;
      fa_d = fa_sel;
      fb_d = fb_sel;
    end
  end

  // NOTE: the file is a flop array, not a RAM macro, so it is cleared on reset like the operand registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_q <= '{default: '0};
      a_q  <= '0;
      b_q  <= '0;
      fa_q <= FWD_FILE;
      fb_q <= FWD_FILE;
    end else begin
      rf_q <= rf_d;
      a_q  <= a_d;
      b_q  <= b_d;
      fa_q <= fa_d;
      fb_q <= fb_d;
    end
  end

  assign bus.A     = a_q;
  assign bus.B     = b_q;
  assign bus.fwd_A = fa_q;
  assign bus.fwd_B = fb_q;
  assign bus.stall = stall;

endmodule

// File: tb/tb_rb_fwd_block.sv
// Scoreboard bench for rb_fwd_block: the same stimulus drives a ZERO_REG=0 and
// a ZERO_REG=1 instance, each checked against its own behavioural model.
module tb_rb_fwd_block;

  localparam int DW = 16;
  localparam int AW = 5;

  typedef struct packed {
    logic          stall;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [1:0]    fa;
    logic [1:0]    fb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] ra, rb, rw_ex, rw_dm, rw_wb;
  logic [DW-1:0] imm, ans_ex, ans_dm, ans_wb;
  logic imm_sel, wr_ex, ld_ex, wr_dm, wr_wb;

  int checks = 0;
  int errors = 0;

  // Model state, index 0 = ZERO_REG off, index 1 = ZERO_REG on.
  logic [DW-1:0] m_file [2][32];
  logic [DW-1:0] m_a [2];
  logic [DW-1:0] m_b [2];
  logic [1:0]    m_fa [2];
  logic [1:0]    m_fb [2];
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  rb_fwd_block_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  rb_fwd_block_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  assign bus0.RA = ra;      assign bus1.RA = ra;
  assign bus0.RB = rb;      assign bus1.RB = rb;
  assign bus0.imm = imm;    assign bus1.imm = imm;
  assign bus0.imm_sel = imm_sel; assign bus1.imm_sel = imm_sel;
  assign bus0.ans_ex = ans_ex;   assign bus1.ans_ex = ans_ex;
  assign bus0.RW_ex = rw_ex;     assign bus1.RW_ex = rw_ex;
  assign bus0.wr_ex = wr_ex;     assign bus1.wr_ex = wr_ex;
  assign bus0.ld_ex = ld_ex;     assign bus1.ld_ex = ld_ex;
  assign bus0.ans_dm = ans_dm;   assign bus1.ans_dm = ans_dm;
  assign bus0.RW_dm = rw_dm;     assign bus1.RW_dm = rw_dm;
  assign bus0.wr_dm = wr_dm;     assign bus1.wr_dm = wr_dm;
  assign bus0.ans_wb = ans_wb;   assign bus1.ans_wb = ans_wb;
  assign bus0.RW_wb = rw_wb;     assign bus1.RW_wb = rw_wb;
  assign bus0.wr_wb = wr_wb;     assign bus1.wr_wb = wr_wb;

  rb_fwd_block #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  rb_fwd_block #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Value of a source register as decode would see it, from the forwarding rules.
  function automatic logic [DW+1:0] lookup(input int d, input logic [AW-1:0] r);
    if (d == 1 && r == 0)               return {2'b00, {DW{1'b0}}};
    if (wr_ex && !ld_ex && rw_ex == r)  return {2'b01, ans_ex};
    if (wr_dm && rw_dm == r)            return {2'b10, ans_dm};
    if (wr_wb && rw_wb == r)            return {2'b11, ans_wb};
    return {2'b00, m_file[d][r]};
  endfunction

  function automatic logic waits_on_load(input int d, input logic [AW-1:0] r);
    return wr_ex && ld_ex && rw_ex == r && !(d == 1 && r == 0);
  endfunction

  // Advance both models over the coming edge and queue what each DUT must show.
  task automatic apply();
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      logic [DW+1:0] pa, pb;
      e.stall = waits_on_load(d, ra) || (!imm_sel && waits_on_load(d, rb));
      pa = lookup(d, ra);
      pb = imm_sel ? {2'b11, imm} : lookup(d, rb);
      if (!rst_n) begin
        for (int i = 0; i < 32; i++) m_file[d][i] = '0;
        m_a[d] = '0; m_b[d] = '0; m_fa[d] = 2'b00; m_fb[d] = 2'b00;
      end else begin
        if (!e.stall) begin
          m_a[d] = pa[DW-1:0]; m_fa[d] = pa[DW+1:DW];
          m_b[d] = pb[DW-1:0]; m_fb[d] = pb[DW+1:DW];
        end
        if (wr_wb && !(d == 1 && rw_wb == 0)) m_file[d][rw_wb] = ans_wb;
      end
      e.a = m_a[d]; e.b = m_b[d]; e.fa = m_fa[d]; e.fb = m_fb[d];
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n = 1'b1; ra = '0; rb = '0; imm = '0; imm_sel = 1'b0;
    ans_ex = '0; rw_ex = '0; wr_ex = 1'b0; ld_ex = 1'b0;
    ans_dm = '0; rw_dm = '0; wr_dm = 1'b0;
    ans_wb = '0; rw_wb = '0; wr_wb = 1'b0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) != 0) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, 31));
  endfunction

  task automatic compare(input string tag, input exp_t e, input logic st,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [1:0] fa, input logic [1:0] fb);
    check({tag, ".stall"}, 32'(st), 32'(e.stall));
    check({tag, ".A"},     32'(a),  32'(e.a));
    check({tag, ".B"},     32'(b),  32'(e.b));
    check({tag, ".fwd_A"}, 32'(fa), 32'(e.fa));
    check({tag, ".fwd_B"}, 32'(fb), 32'(e.fb));
  endtask

  // Monitor: one expected entry per instance after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        compare("zr0", e, bus0.stall, bus0.A, bus0.B, bus0.fwd_A, bus0.fwd_B);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        compare("zr1", e, bus1.stall, bus1.A, bus1.B, bus1.fwd_A, bus1.fwd_B);
      end
    end
  end

  initial begin
    idle();
    rst_n = 1'b0; apply(); apply();

    // Reset clears a previously written register.
    idle(); wr_wb = 1'b1; rw_wb = 5'd5; ans_wb = 16'h1234; apply();
    idle(); rst_n = 1'b0; apply();
    idle(); ra = 5'd5; rb = 5'd5; apply();

    // File read, then ex over dm, then dm alone.
    idle(); wr_wb = 1'b1; rw_wb = 5'd5; ans_wb = 16'hAAAA; apply();
    idle(); ra = 5'd5; apply();
    idle(); ra = 5'd5; wr_ex = 1'b1; rw_ex = 5'd5; ans_ex = 16'hC000;
    wr_dm = 1'b1; rw_dm = 5'd5; ans_dm = 16'hD000; apply();
    wr_ex = 1'b0; apply();

    // WB bypass on the write edge, then a plain file read.
    idle(); rb = 5'd7; wr_wb = 1'b1; rw_wb = 5'd7; ans_wb = 16'hE000; apply();
    idle(); rb = 5'd7; apply();

    // Immediate overrides a load match on B.
    idle(); ra = 5'd1; rb = 5'd2; imm = 16'hFFFF; imm_sel = 1'b1;
    wr_ex = 1'b1; ld_ex = 1'b1; rw_ex = 5'd2; ans_ex = 16'h5555; apply();

    // Load-use stall, then dm forward.
    idle(); ra = 5'd3; wr_ex = 1'b1; ld_ex = 1'b1; rw_ex = 5'd3; ans_ex = 16'h9999; apply();
    idle(); ra = 5'd3; wr_dm = 1'b1; rw_dm = 5'd3; ans_dm = 16'h0042; apply();

    // Register 0: write plus ex/dm hits, then a clean read.
    idle(); ra = 5'd0; rb = 5'd0; wr_wb = 1'b1; rw_wb = 5'd0; ans_wb = 16'hBEEF;
    wr_ex = 1'b1; ld_ex = 1'b1; rw_ex = 5'd0; ans_ex = 16'h1111;
    wr_dm = 1'b1; rw_dm = 5'd0; ans_dm = 16'h2222; apply();
    idle(); ra = 5'd0; wr_dm = 1'b1; rw_dm = 5'd0; ans_dm = 16'h2222; apply();
    idle(); ra = 5'd0; apply();

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      rst_n   = ($urandom_range(0, 49) != 0);
      ra      = rnd_addr();
      rb      = rnd_addr();
      imm     = DW'($urandom);
      imm_sel = ($urandom_range(0, 3) == 0);
      ans_ex  = DW'($urandom); rw_ex = rnd_addr(); wr_ex = $urandom_range(0, 1) == 1;
      ld_ex   = ($urandom_range(0, 2) == 0);
      ans_dm  = DW'($urandom); rw_dm = rnd_addr(); wr_dm = $urandom_range(0, 1) == 1;
      ans_wb  = DW'($urandom); rw_wb = rnd_addr(); wr_wb = $urandom_range(0, 1) == 1;
      apply();
    end

    idle();
    repeat (2) @(posedge clk);
    #2;
    check("sb_drain_zr0", 32'(q0.size()), 32'd0);
    check("sb_drain_zr1", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rb_fwd_block.md
# rb_fwd_block

Parametrised successor to the team's register-bank block. It holds a DATA_W × 2^ADDR_W register file with two read ports and one write-back port. Operand forwarding is resolved internally by comparing source and destination register addresses, so no external mux selects are needed. It also detects load-use hazards and stalls on them. It sits between decode and execute, and registers the A/B operands for the EX stage.

## Interface
Parameters:
- DATA_W, 16, operand/register width
- ADDR_W, 5, register address width (2^ADDR_W registers)
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never forwarded

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- RA  in  ADDR_W  source register for A
- RB  in  ADDR_W  source register for B
- imm  in  DATA_W  immediate operand
- imm_sel  in  1  1 = B takes imm
- ans_ex / RW_ex / wr_ex  in  DATA_W / ADDR_W / 1  EX-stage result, destination and write flag
- ld_ex  in  1  EX instruction is a load; ans_ex not yet valid
- ans_dm / RW_dm / wr_dm  in  DATA_W / ADDR_W / 1  DM-stage result, destination and write flag
- ans_wb / RW_wb / wr_wb  in  DATA_W / ADDR_W / 1  WB result, destination and write enable into the file
- A  out  DATA_W  registered operand A
- B  out  DATA_W  registered operand B
- stall  out  1  combinational load-use stall request to fetch/decode
- fwd_A, fwd_B  out  2  registered source code: 00 file, 01 ex, 10 dm, 11 wb/imm (debug/verification)

## Operation
- Next-A selection, in priority order:
  - RA==0 with ZERO_REG → 0
  - wr_ex && !ld_ex && RW_ex==RA → ans_ex
  - wr_dm && RW_dm==RA → ans_dm
  - wr_wb && RW_wb==RA → ans_wb
  - otherwise → file[RA]
- Next-B selection:
  - imm_sel=1 → imm, fwd_B=11
  - otherwise the same chain as A, using RB
- Priority ex > dm > wb gives the youngest result.
- stall = wr_ex && ld_ex && (RW_ex==RA || (RW_ex==RB && !imm_sel)).
  - A register-0 match never stalls when ZERO_REG=1.
  - An imm-selected B never stalls.
- Write-back: on wr_wb, file[RW_wb] ← ans_wb. This happens regardless of stall, except for register 0 when ZERO_REG=1.
- Same-cycle write and read of the same register returns the new value, via the wb forward path.
- A load in EX never forwards ans_ex. The dm path forwards it one cycle later, after the stall.

## Timing
- Reset (rst_n=0 at a rising edge): A=0, B=0, fwd_A=00, fwd_B=00, all file entries cleared to 0. Reset takes precedence over a simultaneous wr_wb.
- Normal operation: A/B/fwd load the next-values at each rising edge, so latency is 1 cycle from RA/RB to A/B.
- stall=1: A, B, fwd_A and fwd_B hold their previous values. The file write still occurs. stall goes low in the cycle after the load leaves EX, with no further handshake.
- Reset released mid-stall: stall depends only on its inputs; registers restart from 0.
- Address compare uses the full ADDR_W bits; there is no aliasing.

## Structure
- Shared package rb_pkg holds:
  - default DATA_W and ADDR_W
  - fwd source codes FWD_FILE=00, FWD_EX=01, FWD_DM=10, FWD_WB=11
- One sub-module, rb_fwd_sel. It is the combinational priority selector and is instantiated twice (A and B), with an imm override used on B only.
- The file array and the output registers are in the top level.

## Test plan
- Reset: write 'h1234 to r5 via wb, then pulse rst_n=0 → A=B=0; a following read of r5 returns 0.
- File read and priority: file r5='hAAAA; RA=5, wr_ex=1, RW_ex=5, ans_ex='hC000, wr_dm=1, RW_dm=5, ans_dm='hD000 → next cycle A='hC000, fwd_A=01. Drop wr_ex → A='hD000, fwd_A=10.
- WB bypass: RB=7, wr_wb=1, RW_wb=7, ans_wb='hE000, imm_sel=0 → B='hE000 the same edge the file updates. The next read with wr_wb=0 also gives 'hE000.
- Immediate: imm='hFFFF, imm_sel=1, RB matching ex → B='hFFFF, fwd_B=11, stall=0 even if ld_ex=1.
- Load-use: wr_ex=1, ld_ex=1, RW_ex=3, RA=3 → stall=1, A holds. The next cycle presents the load in dm (RW_dm=3, ans_dm='h0042) → stall=0, A='h0042.
- Zero register (ZERO_REG=1): wr_wb to r0 with 'hBEEF, plus ex/dm matches on r0 → A=0 with RA=0, stall=0. Rerun with ZERO_REG=0 → A='hBEEF.
